// File: rtl/branch_stall_ctrl_pkg.sv
// branch_stall_ctrl_pkg
// Shared definitions for the ID-stage branch stall controller:
//   - state_e    : controller FSM states
//   - FWD_RF     : branch operand comes from the register file
//   - FWD_EXMEM  : branch operand comes from the EX/MEM ALU result
//   - REG_ZERO   : index of the hard-wired zero register
//   - dep_need   : stall cycles required by one source operand
//   - need_max   : larger of two stall requirements
package branch_stall_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;

    localparam int REG_ZERO = 0;

    // Stall cycles one operand needs, given where its producer currently sits.
    // A load still in EX needs two cycles before its data reaches a point the
    // ID comparator can use; an ALU result in EX or a load in MEM needs one.
    function automatic logic [1:0] dep_need(input logic ex_dep,
                                            input logic ex_load,
                                            input logic mem_dep,
                                            input logic mem_load);
        logic [1:0] n;
        if (ex_dep && ex_load) begin
            n = 2'd2;
        end else if (ex_dep) begin
            n = 2'd1;
        end else if (mem_dep && mem_load) begin
            n = 2'd1;
        end else begin
            n = 2'd0;
        end
        return n;
    endfunction

    function automatic logic [1:0] need_max(input logic [1:0] a,
                                            input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_stall_ctrl_dep_detect.sv
// branch_dep_detect
// Combinational hazard detection for a branch resolved in ID.
// Ports:
//   id_rs, id_rt                         branch source registers
//   ex_reg_write, ex_mem_read, ex_rd     EX-stage producer
//   mem_reg_write, mem_mem_read, mem_rd  MEM-stage producer
//   need                                 stall cycles required (0..2)
//   fwd_rs, fwd_rt                       operand select (FWD_RF / FWD_EXMEM)
module branch_dep_detect
    import branch_stall_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    output logic [1:0]       need,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt
);

    localparam logic [REG_W-1:0] RZ = REG_W'(REG_ZERO);

    logic rs_ex_dep_s;
    logic rt_ex_dep_s;
    logic rs_mem_dep_s;
    logic rt_mem_dep_s;

    // Dependence matching, stall requirement and forwarding selection.
    always_comb begin
        rs_ex_dep_s  = ex_reg_write  && (id_rs != RZ) && (id_rs == ex_rd);
        rt_ex_dep_s  = ex_reg_write  && (id_rt != RZ) && (id_rt == ex_rd);
        rs_mem_dep_s = mem_reg_write && (id_rs != RZ) && (id_rs == mem_rd);
        rt_mem_dep_s = mem_reg_write && (id_rt != RZ) && (id_rt == mem_rd);

        need = need_max(dep_need(rs_ex_dep_s, ex_mem_read, rs_mem_dep_s, mem_mem_read),
                        dep_need(rt_ex_dep_s, ex_mem_read, rt_mem_dep_s, mem_mem_read));

        // The EX producer is younger, so a match there shadows any MEM match.
        if (rs_mem_dep_s && !mem_mem_read && !rs_ex_dep_s) begin
            fwd_rs = FWD_EXMEM;
        end else begin
            fwd_rs = FWD_RF;
        end

        if (rt_mem_dep_s && !mem_mem_read && !rt_ex_dep_s) begin
            fwd_rt = FWD_EXMEM;
        end else begin
            fwd_rt = FWD_RF;
        end
    end

endmodule

// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl
// Stalls a branch in ID until its operands can be compared, then resolves it.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/stall counters.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   id_branch, id_bne         branch in ID and its type (1 = BNE, 0 = BEQ)
//   id_rs, id_rt              branch source registers
//   ex_* / mem_*              EX- and MEM-stage producers
//   equal_registers_in        ID comparator result on forwarded operands
//   stall                     hold PC and IF/ID, bubble into ID/EX
//   fwd_rs, fwd_rt            operand select (00 regfile, 01 EX/MEM)
//   branch_taken, flush_ifid  redirect PC / zero IF/ID (one-cycle pulse)
//   taken_cnt, stall_cnt      statistics (BRANCH_STATS_EN only)
module branch_stall_ctrl
    import branch_stall_ctrl_pkg::*;
#(
    parameter int STAT_W = 16,
    parameter int REG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_branch,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             equal_registers_in,
    output logic             stall,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             branch_taken,
    output logic             flush_ifid
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic [1:0] need_s;
    logic [1:0] fwd_rs_s;
    logic [1:0] fwd_rt_s;
    logic       stall_s;
    logic       resolve_s;
    logic       taken_s;

    branch_dep_detect #(
        .REG_W (REG_W)
    ) u_dep (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .need          (need_s),
        .fwd_rs        (fwd_rs_s),
        .fwd_rt        (fwd_rt_s)
    );

    // FSM state and remaining-stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; the stall need is sampled once on entry and then
    // counted down, since the producer keeps moving while we wait.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        resolve_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (id_branch && (need_s != 2'd0)) begin
                    stall_s     = 1'b1;
                    cnt_nxt_s   = need_s - 2'd1;
                    state_nxt_s = ST_STALL;
                end else if (id_branch) begin
                    resolve_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!id_branch) begin
                    // Branch left ID (e.g. squashed): drop it silently.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 2'd0;
                end else if (cnt_r != 2'd0) begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r - 2'd1;
                end else begin
                    resolve_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
        taken_s = resolve_s & (equal_registers_in ^ id_bne);
    end

    // Output drive; everything is forced low while reset is held.
    always_comb begin
        if (reset) begin
            stall        = 1'b0;
            branch_taken = 1'b0;
            flush_ifid   = 1'b0;
            fwd_rs       = FWD_RF;
            fwd_rt       = FWD_RF;
        end else begin
            stall        = stall_s;
            branch_taken = taken_s;
            flush_ifid   = taken_s;
            fwd_rs       = fwd_rs_s;
            fwd_rt       = fwd_rt_s;
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] taken_cnt_r;
    logic [STAT_W-1:0] stall_cnt_r;

    // Saturating statistics counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taken_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (branch_taken && (taken_cnt_r != STAT_MAX)) begin
                taken_cnt_r <= taken_cnt_r + STAT_W'(1);
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
            if (stall && (stall_cnt_r != STAT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + STAT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign taken_cnt = taken_cnt_r;
    assign stall_cnt = stall_cnt_r;
`else
    // Statistics are compiled out; STAT_W has no effect in this build.
    if (STAT_W > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Testbench for branch_stall_ctrl: directed vectors, expected outputs pushed
// to a scoreboard queue at drive time and popped on the falling clock edge.
module tb_branch_stall_ctrl;

    logic       clock;
    logic       reset;
    logic       id_branch;
    logic       id_bne;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       mem_reg_write;
    logic       mem_mem_read;
    logic [4:0] mem_rd;
    logic       equal_registers_in;
    logic       stall;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       branch_taken;
    logic       flush_ifid;
`ifdef BRANCH_STATS_EN
    logic [1:0] taken_cnt;
    logic [1:0] stall_cnt;
`endif

    branch_stall_ctrl #(
        .STAT_W (2),
        .REG_W  (5)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .id_branch          (id_branch),
        .id_bne             (id_bne),
        .id_rs              (id_rs),
        .id_rt              (id_rt),
        .ex_reg_write       (ex_reg_write),
        .ex_mem_read        (ex_mem_read),
        .ex_rd              (ex_rd),
        .mem_reg_write      (mem_reg_write),
        .mem_mem_read       (mem_mem_read),
        .mem_rd             (mem_rd),
        .equal_registers_in (equal_registers_in),
        .stall              (stall),
        .fwd_rs             (fwd_rs),
        .fwd_rt             (fwd_rt),
        .branch_taken       (branch_taken),
        .flush_ifid         (flush_ifid)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt          (taken_cnt),
        .stall_cnt          (stall_cnt)
`endif
    );

    // Expected output vector: {stall, branch_taken, flush_ifid, fwd_rs, fwd_rt}
    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  exp_taken = 0;
    int  exp_stall = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic br, input logic bne,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic exw, input logic exl, input logic [4:0] exrd,
                         input logic mw, input logic ml, input logic [4:0] mrd,
                         input logic eq, input logic [6:0] exp);
        sb_t e;
        id_branch          = br;
        id_bne             = bne;
        id_rs              = rs;
        id_rt              = rt;
        ex_reg_write       = exw;
        ex_mem_read        = exl;
        ex_rd              = exrd;
        mem_reg_write      = mw;
        mem_mem_read       = ml;
        mem_rd             = mrd;
        equal_registers_in = eq;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic step();
        sb_t e;
        @(negedge clock);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, {stall, branch_taken, flush_ifid, fwd_rs, fwd_rt}, e.exp);
            if (reset) begin
                exp_taken = 0;
                exp_stall = 0;
            end else begin
                if (e.exp[5] && exp_taken < 3) exp_taken++;
                if (e.exp[6] && exp_stall < 3) exp_stall++;
            end
        end
        @(posedge clock);
        #1;
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, exp_taken);
        chk("stall_cnt", stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        reset = 1'b1;
        // Outputs held low during reset even with hazards on the inputs.
        drive("rst_out",  1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 7'b0000000); step();
        reset = 1'b0;

        // BEQ behind an EX load: two stall cycles, resolve taken in the third.
        drive("lw_s1",    1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b1000000); step();
        drive("lw_s2",    1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b1000000); step();
        drive("lw_res",   1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0110000); step();
        drive("nonbr",    1'b0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0000000); step();

        // BNE behind an EX ALU op: one stall; producer moves to MEM and is forwarded.
        drive("alu_s1",   1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 7'b1000000); step();
        drive("alu_res",  1'b1, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 7'b0000100); step();

        // MEM ALU producer on rt: forwarded, no stall, taken at once.
        drive("mem_fwd",  1'b1, 1'b0, 5'd1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 7'b0110001); step();
        // Register zero never creates a dependence.
        drive("r0_ex",    1'b1, 1'b0, 5'd0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 7'b0110000); step();

        // MEM load on rt: one stall, BNE with unequal operands is taken.
        drive("mld_s1",   1'b1, 1'b1, 5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 7'b1000000); step();
        drive("mld_res",  1'b1, 1'b1, 5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 7'b0110000); step();

        // Producer without reg_write is not a dependence.
        drive("no_wr",    1'b1, 1'b0, 5'd6, 5'd1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 7'b0000000); step();

        // rs forwarded from MEM, rt behind an EX load: maximum need of 2 wins.
        drive("max_s1",   1'b1, 1'b0, 5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd4, 1'b0, 7'b1000100); step();
        drive("max_s2",   1'b1, 1'b0, 5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd4, 1'b0, 7'b1000100); step();
        drive("max_res",  1'b1, 1'b0, 5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd4, 1'b0, 7'b0000100); step();

        // Branch vanishes mid-stall: nothing fires, controller back to idle.
        drive("drop_s1",  1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b1000000); step();
        drive("drop",     1'b0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0000000); step();
        drive("drop_new", 1'b1, 1'b0, 5'd11, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0110000); step();

        // Both operands forwarded from MEM.
        drive("both_fwd", 1'b1, 1'b0, 5'd10, 5'd10, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 7'b0110101); step();

        // Reset in the second stall cycle abandons the branch.
        drive("rst_s1",   1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b1000000); step();
        reset = 1'b1;
        drive("rst_mid",  1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0000000); step();
        reset = 1'b0;
        drive("rst_rel",  1'b0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0000000); step();
        drive("rst_idle", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0000000); step();

        // Four taken branches in a row.
        for (int i = 0; i < 4; i++) begin
            drive("taken_run", 1'b1, 1'b0, 5'd13, 5'd14, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 7'b0110000); step();
        end
`ifdef BRANCH_STATS_EN
        chk("taken_sat", taken_cnt, 32'd3);
`endif
        drive("idle_end", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 7'b0000000); step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_stall_ctrl.md
BRANCH_STALL_CTRL -- requirements
Module: branch_stall_ctrl

Interface
REQ-001 SHALL have parameter STAT_W, default 16, width of the statistics counters.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have port clock, input, 1, single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port id_branch, input, 1, the instruction in ID is a branch.
REQ-006 SHALL have port id_bne, input, 1, branch type: 1 = BNE, 0 = BEQ.
REQ-007 SHALL have ports id_rs and id_rt, input, REG_W each, branch source registers.
REQ-008 SHALL have ports ex_reg_write, ex_mem_read, input, 1 each, and ex_rd, input, REG_W: the EX-stage producer.
REQ-009 SHALL have ports mem_reg_write, mem_mem_read, input, 1 each, and mem_rd, input, REG_W: the MEM-stage producer.
REQ-010 SHALL have port equal_registers_in, input, 1, the ID comparator result on the forwarded operands.
REQ-011 SHALL have port stall, output, 1, hold PC and IF/ID and insert a bubble into ID/EX.
REQ-012 SHALL have ports fwd_rs and fwd_rt, output, 2 each: 00 register file, 01 EX/MEM ALU result.
REQ-013 SHALL have port branch_taken, output, 1, redirect the PC to the branch target.
REQ-014 SHALL have port flush_ifid, output, 1, zero the IF/ID register.
REQ-015 SHALL have ports taken_cnt and stall_cnt, output, STAT_W each, present only under BRANCH_STATS_EN.

Function
REQ-016 SHALL treat a source as dependent only when it is non-zero and equals the producer rd with that producer's reg_write set.
REQ-017 SHALL compute the stall need N as follows: EX load dependence gives N=2; EX ALU dependence gives N=1; MEM load dependence gives N=1; otherwise N=0. The maximum applies over rs and rt.
REQ-018 SHALL, for a MEM-stage ALU dependence (no load), set the matching fwd_* to 01 with no stall; otherwise fwd_* SHALL be 00.
REQ-019 SHALL implement FSM states IDLE and STALL plus a 2-bit down-counter cnt.
REQ-020 In IDLE with id_branch and N>0, the block SHALL assert stall combinationally in the same cycle, load cnt=N-1, and go to STALL.
REQ-021 In STALL with cnt!=0, the block SHALL assert stall, decrement cnt, and remain in STALL.
REQ-022 In STALL with cnt==0, the block SHALL deassert stall, resolve the branch, and go to IDLE.
REQ-023 Resolving the branch SHALL mean: taken = equal_registers_in XOR id_bne; branch_taken = flush_ifid = taken, a one-cycle combinational pulse.
REQ-024 In IDLE with id_branch and N=0, the block SHALL resolve in the same cycle with no stall.
REQ-025 If id_branch deasserts while in STALL, the block SHALL return to IDLE with no branch_taken, flush_ifid or stall.
REQ-026 branch_taken, flush_ifid and stall SHALL never assert in the same cycle.
REQ-027 A non-branch instruction in ID SHALL produce stall=0, branch_taken=0 and flush_ifid=0.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, cnt=0, and both statistics counters to 0.
REQ-029 During reset, every output SHALL be 0 (fwd_*=00).
REQ-030 Reset asserted mid-stall SHALL abandon the pending branch, with no branch_taken after release.

Configuration
REQ-031 With BRANCH_STATS_EN defined, taken_cnt SHALL increment on every branch_taken cycle, stall_cnt SHALL increment on every stall cycle, and both SHALL saturate at all-ones.
REQ-032 Without BRANCH_STATS_EN, the counters and their ports SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef, the forwarding-select encodings FWD_RF=2'b00 and FWD_EXMEM=2'b01, and the constant for register index zero.
REQ-034 Hazard detection SHALL be a natural sub-module named branch_dep_detect: combinational, outputting N and fwd_*.
REQ-035 The FSM and the counters SHALL reside in branch_stall_ctrl.

Verification
REQ-036 Scenario: BEQ rs=3, rt=4; EX lw rd=3 -> stall for 2 cycles; resolve in the third cycle; equal=1 gives branch_taken=1 and flush_ifid=1.
REQ-037 Scenario: BNE rs=5; EX add rd=5 -> stall for 1 cycle; then equal=1 gives branch_taken=0.
REQ-038 Scenario: BEQ rt=7; MEM add rd=7 -> no stall; fwd_rt=01; equal=1 gives branch_taken=1 in the same cycle.
REQ-039 Scenario: BEQ rs=0; EX lw rd=0 -> no stall; fwd_rs=00.
REQ-040 Scenario: reset asserted in the second stall cycle of the EX lw case -> outputs go to 0 immediately; no branch_taken after release.
REQ-041 Scenario (BRANCH_STATS_EN, STAT_W=2): four taken branches -> taken_cnt saturates at 3.
